// File: rtl/oflow_fe_reg_sb_access_ctrl.sv
// Access controller for the feature-extraction scoreboard bank: in-order row allocation
// for registration writes, round-robin PE reads, per-row validity and per-frame clearing.
module oflow_fe_reg_sb_access_ctrl #(
    parameter int NUM_PE   = 4,
    parameter int MAX_ROWS = 16,
    parameter int ROW_LEN  = $clog2(MAX_ROWS),
    parameter int FE_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      ready_new_frame,
    input  logic                      reg_req,
    input  logic [FE_W-1:0]           reg_data,
    output logic                      reg_ack,
    output logic [ROW_LEN-1:0]        reg_row,
    output logic                      reg_full,
    output logic                      reg_err,
    input  logic [NUM_PE-1:0]         pe_req,
    input  logic [NUM_PE*ROW_LEN-1:0] pe_addr,
    output logic [NUM_PE-1:0]         pe_gnt,
    output logic [NUM_PE-1:0]         pe_rd_valid,
    output logic [FE_W-1:0]           pe_rd_data,
    output logic                      pe_rd_miss,
    output logic [ROW_LEN-1:0]        sb_addr,
    output logic                      sb_we,
    output logic [FE_W-1:0]           sb_data_in,
    input  logic [FE_W-1:0]           sb_data_out,
    output logic [ROW_LEN:0]          row_count
);

    localparam int RR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_t;

    logic [ROW_LEN:0]     count_q;
    logic [MAX_ROWS-1:0]  valid_q;
    logic [RR_W-1:0]      rr_q;
    logic                 last_wr_q;
    logic [NUM_PE-1:0]    rd_valid_q;
    logic [FE_W-1:0]      rd_data_q;
    logic                 rd_miss_q;

    op_t                  op;
    logic                 full;
    logic                 rr_hit;
    logic [RR_W-1:0]      rr_sel;
    logic [ROW_LEN-1:0]   wr_ptr;
    logic [ROW_LEN-1:0]   rd_addr;

    assign full   = (count_q == (ROW_LEN+1)'(MAX_ROWS));
    assign wr_ptr = count_q[ROW_LEN-1:0];

    // first requester at or after rr_q, wrapping
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (!rr_hit && pe_req[RR_W'((int'(rr_q) + k) % NUM_PE)]) begin
                rr_hit = 1'b1;
                rr_sel = RR_W'((int'(rr_q) + k) % NUM_PE);
            end
        end
    end

    assign rd_addr = pe_addr[int'(rr_sel)*ROW_LEN +: ROW_LEN];

    // a write yields to pending reads when the previous op was also a write
    always_comb begin
        op = OP_IDLE;
        if (!reset_N || ready_new_frame)
            op = OP_IDLE;
        else if (reg_req && !full && !(last_wr_q && rr_hit))
            op = OP_WRITE;
        else if (rr_hit)
            op = OP_READ;
    end

    assign sb_we      = (op == OP_WRITE);
    assign sb_addr    = (op == OP_WRITE) ? wr_ptr : (op == OP_READ) ? rd_addr : '0;
    assign sb_data_in = reset_N ? reg_data : '0;
    assign reg_ack    = (op == OP_WRITE);
    assign reg_row    = (op == OP_WRITE) ? wr_ptr : '0;
    assign reg_err    = reset_N && !ready_new_frame && reg_req && full;
    assign reg_full   = full;
    assign row_count  = count_q;
    assign pe_gnt     = (op == OP_READ) ? (NUM_PE'(1) << rr_sel) : '0;
    assign pe_rd_valid = rd_valid_q;
    assign pe_rd_data  = rd_data_q;
    assign pe_rd_miss  = rd_miss_q;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            count_q    <= '0;
            valid_q    <= '0;
            rr_q       <= '0;
            last_wr_q  <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_miss_q  <= 1'b0;
        end else begin
            rd_valid_q <= pe_gnt;
            if (op == OP_READ) begin
                rd_data_q <= sb_data_out;
                rd_miss_q <= ~valid_q[rd_addr];
            end
            if (ready_new_frame) begin
                count_q   <= '0;
                valid_q   <= '0;
                rr_q      <= '0;
                last_wr_q <= 1'b0;
            end else begin
                last_wr_q <= (op == OP_WRITE);
                if (op == OP_WRITE) begin
                    valid_q[wr_ptr] <= 1'b1;
                    count_q         <= count_q + (ROW_LEN+1)'(1);
                end
                if (op == OP_READ)
                    rr_q <= RR_W'((int'(rr_sel) + 1) % NUM_PE);
            end
        end
    end

endmodule

// File: tb/tb_oflow_fe_reg_sb_access_ctrl.sv
// Bench for oflow_fe_reg_sb_access_ctrl: directed scenarios with constant expectations
// plus a randomized run against a cycle-level behavioural model of the bank access rules.
module tb_oflow_fe_reg_sb_access_ctrl;

    localparam int NUM_PE   = 4;
    localparam int MAX_ROWS = 8;
    localparam int ROW_LEN  = 3;
    localparam int FE_W     = 8;

    logic                      clk = 1'b0;
    logic                      reset_N = 1'b0;
    logic                      ready_new_frame = 1'b0;
    logic                      reg_req = 1'b0;
    logic [FE_W-1:0]           reg_data = '0;
    logic                      reg_ack;
    logic [ROW_LEN-1:0]        reg_row;
    logic                      reg_full;
    logic                      reg_err;
    logic [NUM_PE-1:0]         pe_req = '0;
    logic [NUM_PE*ROW_LEN-1:0] pe_addr = '0;
    logic [NUM_PE-1:0]         pe_gnt;
    logic [NUM_PE-1:0]         pe_rd_valid;
    logic [FE_W-1:0]           pe_rd_data;
    logic                      pe_rd_miss;
    logic [ROW_LEN-1:0]        sb_addr;
    logic                      sb_we;
    logic [FE_W-1:0]           sb_data_in;
    logic [FE_W-1:0]           sb_data_out;
    logic [ROW_LEN:0]          row_count;

    oflow_fe_reg_sb_access_ctrl #(
        .NUM_PE(NUM_PE), .MAX_ROWS(MAX_ROWS), .ROW_LEN(ROW_LEN), .FE_W(FE_W)
    ) dut (
        .clk(clk), .reset_N(reset_N), .ready_new_frame(ready_new_frame),
        .reg_req(reg_req), .reg_data(reg_data), .reg_ack(reg_ack), .reg_row(reg_row),
        .reg_full(reg_full), .reg_err(reg_err), .pe_req(pe_req), .pe_addr(pe_addr),
        .pe_gnt(pe_gnt), .pe_rd_valid(pe_rd_valid), .pe_rd_data(pe_rd_data),
        .pe_rd_miss(pe_rd_miss), .sb_addr(sb_addr), .sb_we(sb_we),
        .sb_data_in(sb_data_in), .sb_data_out(sb_data_out), .row_count(row_count)
    );

    always #5 clk = ~clk;

    // scoreboard bank: combinational read, cleared by frame start
    logic [FE_W-1:0] bank [MAX_ROWS];
    assign sb_data_out = bank[sb_addr];
    always @(posedge clk) begin
        if (ready_new_frame) begin
            for (int i = 0; i < MAX_ROWS; i++) bank[i] <= '0;
        end else if (sb_we) begin
            bank[sb_addr] <= sb_data_in;
        end
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    int              m_count;
    int              m_rr;
    bit              m_lastw;
    bit              m_valid [MAX_ROWS];
    logic [FE_W-1:0] m_mem   [MAX_ROWS];
    logic [NUM_PE-1:0] e_rd_valid;
    logic [FE_W-1:0]   e_rd_data;
    bit                e_rd_miss;
    int                e_op;   // 0 idle, 1 write, 2 read
    int                e_pe;

    function automatic int addr_of(int i);
        return int'(pe_addr[i*ROW_LEN +: ROW_LEN]);
    endfunction

    function automatic void model_decide();
        bit found;
        e_op = 0;
        e_pe = 0;
        found = 0;
        if (reset_N && !ready_new_frame) begin
            if (reg_req && m_count < MAX_ROWS && !(m_lastw && pe_req != 0)) begin
                e_op = 1;
            end else if (pe_req != 0) begin
                e_op = 2;
                for (int k = 0; k < NUM_PE; k++) begin
                    if (!found && pe_req[(m_rr + k) % NUM_PE]) begin
                        found = 1;
                        e_pe = (m_rr + k) % NUM_PE;
                    end
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_rr = 0;
        m_lastw = 0;
        e_rd_valid = '0;
        e_rd_data = '0;
        e_rd_miss = 0;
        for (int i = 0; i < MAX_ROWS; i++) m_valid[i] = 0;
    endtask

    task automatic set_in(input bit rnf, input bit rq, input logic [FE_W-1:0] d,
                          input logic [NUM_PE-1:0] pr, input logic [ROW_LEN-1:0] a);
        ready_new_frame = rnf;
        reg_req = rq;
        reg_data = d;
        pe_req = pr;
        pe_addr = {NUM_PE{a}};
    endtask

    // one clock: model advances with the inputs present at the edge
    task automatic tick();
        model_decide();
        @(posedge clk);
        if (e_op == 2) begin
            e_rd_data  = m_mem[addr_of(e_pe)];
            e_rd_miss  = !m_valid[addr_of(e_pe)];
            e_rd_valid = NUM_PE'(1 << e_pe);
            m_rr       = (e_pe + 1) % NUM_PE;
        end else begin
            e_rd_valid = '0;
        end
        if (ready_new_frame) begin
            m_count = 0;
            m_rr = 0;
            m_lastw = 0;
            for (int i = 0; i < MAX_ROWS; i++) begin
                m_valid[i] = 0;
                m_mem[i] = '0;
            end
        end else begin
            if (e_op == 1) begin
                m_mem[m_count] = reg_data;
                m_valid[m_count] = 1;
                m_count++;
            end
            m_lastw = (e_op == 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(0, 1, 8'h3C, 4'hF, 3'd5);
        #1;
        checks++;
        if ({reg_ack, reg_err, reg_full, sb_we, pe_rd_miss} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000", {reg_ack, reg_err, reg_full, sb_we, pe_rd_miss});
        end
        checks++;
        if (pe_gnt !== 4'b0 || pe_rd_valid !== 4'b0) begin
            errors++;
            $display("FAIL reset_pe: gnt %b valid %b exp 0", pe_gnt, pe_rd_valid);
        end
        checks++;
        if (sb_addr !== 3'd0 || reg_row !== 3'd0 || row_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_addr: sb_addr %0d reg_row %0d row_count %0d exp 0", sb_addr, reg_row, row_count);
        end
        checks++;
        if (sb_data_in !== 8'h00 || pe_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: sb_data_in %h pe_rd_data %h exp 00", sb_data_in, pe_rd_data);
        end
        @(negedge clk);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        reset_N = 1'b1;
        model_reset();
    endtask

    task automatic test_writes();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, FE_W'(8'h11 * (i + 1)), 0, 0);
            #1;
            checks++;
            if (reg_ack !== 1'b1 || reg_row !== ROW_LEN'(i) || sb_we !== 1'b1 || sb_addr !== ROW_LEN'(i)) begin
                errors++;
                $display("FAIL write_%0d: ack %b row %0d we %b addr %0d exp ack 1 row %0d", i, reg_ack, reg_row, sb_we, sb_addr, i);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (row_count !== 4'd3 || reg_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_count: row_count %0d ack %b exp 3 0", row_count, reg_ack);
        end
        tick();
    endtask

    task automatic test_read();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 8'h5A, 0, 0);
        tick();
        set_in(0, 1, 8'hA5, 0, 0);
        tick();
        set_in(0, 0, 0, 4'b0001, 3'd1);
        #1;
        checks++;
        if (pe_gnt !== 4'b0001 || sb_addr !== 3'd1 || sb_we !== 1'b0) begin
            errors++;
            $display("FAIL read_gnt: gnt %b addr %0d we %b exp 0001 1 0", pe_gnt, sb_addr, sb_we);
        end
        tick();
        checks++;
        if (pe_rd_valid !== 4'b0001 || pe_rd_data !== 8'hA5 || pe_rd_miss !== 1'b0) begin
            errors++;
            $display("FAIL read_hit: valid %b data %h miss %b exp 0001 a5 0", pe_rd_valid, pe_rd_data, pe_rd_miss);
        end
        set_in(0, 0, 0, 4'b0001, 3'd5);
        #1;
        checks++;
        if (pe_gnt !== 4'b0001 || sb_addr !== 3'd5) begin
            errors++;
            $display("FAIL read_gnt5: gnt %b addr %0d exp 0001 5", pe_gnt, sb_addr);
        end
        tick();
        checks++;
        if (pe_rd_valid !== 4'b0001 || pe_rd_data !== 8'h00 || pe_rd_miss !== 1'b1) begin
            errors++;
            $display("FAIL read_miss: valid %b data %h miss %b exp 0001 00 1", pe_rd_valid, pe_rd_data, pe_rd_miss);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_interleave();
        logic [4:0] exp_v;
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 4'hF, 3'd2);
        for (int k = 0; k < 10; k++) begin
            reg_data = FE_W'($urandom);
            pe_addr = NUM_PE*ROW_LEN'($urandom);
            #1;
            exp_v = (k % 2 == 0) ? 5'b10000 : {1'b0, 4'(1 << ((k / 2) % 4))};
            checks++;
            if ({reg_ack, pe_gnt} !== exp_v) begin
                errors++;
                $display("FAIL interleave_%0d: ack/gnt %b exp %b", k, {reg_ack, pe_gnt}, exp_v);
            end
            tick();
        end
        checks++;
        if (row_count !== 4'd5) begin
            errors++;
            $display("FAIL interleave_count: row_count %0d exp 5", row_count);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_full();
        set_in(1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < MAX_ROWS; i++) begin
            set_in(0, 1, FE_W'(8'h40 + i), 0, 0);
            tick();
        end
        set_in(0, 1, 8'h77, 0, 0);
        #1;
        checks++;
        if (reg_full !== 1'b1 || row_count !== 4'd8) begin
            errors++;
            $display("FAIL full_flag: full %b row_count %0d exp 1 8", reg_full, row_count);
        end
        checks++;
        if (reg_ack !== 1'b0 || reg_err !== 1'b1 || sb_we !== 1'b0) begin
            errors++;
            $display("FAIL full_reject: ack %b err %b we %b exp 0 1 0", reg_ack, reg_err, sb_we);
        end
        tick();
        set_in(0, 1, 8'h77, 4'b0010, 3'd2);
        #1;
        checks++;
        if (pe_gnt !== 4'b0010 || reg_err !== 1'b1 || sb_we !== 1'b0) begin
            errors++;
            $display("FAIL full_pe_take: gnt %b err %b we %b exp 0010 1 0", pe_gnt, reg_err, sb_we);
        end
        tick();
        checks++;
        if (pe_rd_valid !== 4'b0010 || pe_rd_data !== 8'h42 || pe_rd_miss !== 1'b0 || row_count !== 4'd8) begin
            errors++;
            $display("FAIL full_read: valid %b data %h miss %b count %0d exp 0010 42 0 8", pe_rd_valid, pe_rd_data, pe_rd_miss, row_count);
        end
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (reg_err !== 1'b0) begin
            errors++;
            $display("FAIL full_err_drop: err %b exp 0", reg_err);
        end
    endtask

    task automatic test_new_frame();
        set_in(0, 0, 0, 4'b0100, 3'd3);
        tick();
        set_in(1, 1, 8'h99, 4'hF, 3'd3);
        #1;
        checks++;
        if (pe_gnt !== 4'b0 || reg_ack !== 1'b0 || sb_we !== 1'b0) begin
            errors++;
            $display("FAIL nf_quiet: gnt %b ack %b we %b exp 0", pe_gnt, reg_ack, sb_we);
        end
        checks++;
        if (pe_rd_valid !== 4'b0100 || pe_rd_data !== 8'h43) begin
            errors++;
            $display("FAIL nf_inflight: valid %b data %h exp 0100 43", pe_rd_valid, pe_rd_data);
        end
        tick();
        checks++;
        if (row_count !== 4'd0 || reg_full !== 1'b0 || pe_rd_valid !== 4'b0) begin
            errors++;
            $display("FAIL nf_clear: count %0d full %b valid %b exp 0 0 0", row_count, reg_full, pe_rd_valid);
        end
        set_in(0, 1, 8'h12, 0, 0);
        #1;
        checks++;
        if (reg_ack !== 1'b1 || reg_row !== 3'd0) begin
            errors++;
            $display("FAIL nf_first_row: ack %b row %0d exp 1 0", reg_ack, reg_row);
        end
        tick();
        set_in(0, 0, 0, 4'b0001, 3'd3);
        tick();
        checks++;
        if (pe_rd_valid !== 4'b0001 || pe_rd_miss !== 1'b1 || pe_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL nf_old_row: valid %b miss %b data %h exp 0001 1 00", pe_rd_valid, pe_rd_miss, pe_rd_data);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 4'b1000, 3'd0);
        #1;
        checks++;
        if (pe_gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid_gnt: gnt %b exp 1000", pe_gnt);
        end
        reset_N = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pe_rd_valid !== 4'b0 || pe_gnt !== 4'b0 || row_count !== 4'd0 || reg_ack !== 1'b0 || sb_addr !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: valid %b gnt %b count %0d ack %b addr %0d exp 0", pe_rd_valid, pe_gnt, row_count, reg_ack, sb_addr);
        end
        set_in(0, 0, 0, 0, 0);
        reset_N = 1'b1;
        model_reset();
        set_in(0, 1, 8'h66, 0, 0);
        #1;
        checks++;
        if (reg_ack !== 1'b1 || reg_row !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_row: ack %b row %0d exp 1 0", reg_ack, reg_row);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [17:0] got_c, exp_c;
        int          exp_addr;
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom % 40) == 0, $urandom % 2, FE_W'($urandom), NUM_PE'($urandom), 0);
            pe_addr = NUM_PE*ROW_LEN'($urandom);
            #1;
            model_decide();
            exp_addr = (e_op == 1) ? m_count : (e_op == 2) ? addr_of(e_pe) : 0;
            got_c = {reg_ack, reg_row, sb_we, sb_addr, pe_gnt, reg_err, reg_full, row_count};
            exp_c = {e_op == 1, (e_op == 1) ? ROW_LEN'(m_count) : ROW_LEN'(0), e_op == 1,
                     ROW_LEN'(exp_addr), (e_op == 2) ? NUM_PE'(1 << e_pe) : NUM_PE'(0),
                     !ready_new_frame && reg_req && m_count == MAX_ROWS,
                     m_count == MAX_ROWS, (ROW_LEN+1)'(m_count)};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL rand_comb_%0d: got %h exp %h", n, got_c, exp_c);
            end
            checks++;
            if (pe_rd_valid !== e_rd_valid || sb_data_in !== reg_data) begin
                errors++;
                $display("FAIL rand_valid_%0d: valid %b din %h exp %b %h", n, pe_rd_valid, sb_data_in, e_rd_valid, reg_data);
            end
            if (e_rd_valid != 0) begin
                checks++;
                if (pe_rd_data !== e_rd_data || pe_rd_miss !== e_rd_miss) begin
                    errors++;
                    $display("FAIL rand_data_%0d: data %h miss %b exp %h %b", n, pe_rd_data, pe_rd_miss, e_rd_data, e_rd_miss);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < MAX_ROWS; i++) begin
            bank[i] = '0;
            m_mem[i] = '0;
        end
        model_reset();
        test_reset();
        test_writes();
        test_read();
        test_interleave();
        test_full();
        test_new_frame();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
